// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared states, board region codes and default decode/wait tables
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [2:0] REGION_RAM = 3'd0;
    localparam logic [2:0] REGION_GPU = 3'd1;
    localparam logic [2:0] REGION_IO  = 3'd2;
    localparam logic [2:0] REGION_ROM = 3'd3;

    // Slave 0 occupies the least significant field of the packed tables.
    function automatic logic [11:0] pack4x3(input logic [2:0] s3, input logic [2:0] s2,
                                            input logic [2:0] s1, input logic [2:0] s0);
        return {s3, s2, s1, s0};
    endfunction

    localparam logic [11:0] DEF_BASES = pack4x3(REGION_ROM, REGION_IO, REGION_GPU, REGION_RAM);
    localparam logic [11:0] DEF_WAITS = pack4x3(3'd0, 3'd2, 3'd1, 3'd0);

endpackage

// File: rtl/bus_decode.sv
// rtl/bus_decode.sv - address region decode with lowest-index priority
module bus_decode
    import bus_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int N_SLV  = 4,
    parameter int SEL_W  = 3,
    parameter int IDX_W  = 2,
    parameter logic [N_SLV*SEL_W-1:0] BASES = DEF_BASES
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic [N_SLV-1:0]  o_onehot,
    output logic              o_hit,
    output logic [IDX_W-1:0]  o_idx
);

    always_comb begin
        o_onehot = '0;
        o_hit    = 1'b0;
        o_idx    = '0;
        // Scan downwards so the lowest matching slave is the last one written.
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if (i_addr[ADDR_W-1 -: SEL_W] == BASES[i*SEL_W +: SEL_W]) begin
                o_hit = 1'b1;
                o_idx = IDX_W'(i);
            end
        end
        if (o_hit) begin
            o_onehot[o_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/bus_fabric.sv
// rtl/bus_fabric.sv - cpu-to-slave interconnect with wait states, stall and timeout
module bus_fabric
    import bus_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int N_SLV   = 4,
    parameter int SEL_W   = 3,
    parameter logic [N_SLV*SEL_W-1:0] BASES = DEF_BASES,
    parameter logic [N_SLV*3-1:0]     WAITS = DEF_WAITS,
    parameter int TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_W-1:0]       cpu_addr,
    input  logic [DATA_W-1:0]       cpu_wdata,
    input  logic                    cpu_read,
    input  logic                    cpu_write,
    output logic [DATA_W-1:0]       cpu_rdata,
    output logic                    cpu_ready,
    output logic                    bus_error,
    output logic [N_SLV-1:0]        slv_sel,
    output logic [ADDR_W-SEL_W-1:0] slv_addr,
    output logic [DATA_W-1:0]       slv_wdata,
    output logic                    slv_read,
    output logic                    slv_write,
    input  logic [N_SLV*DATA_W-1:0] slv_rdata,
    input  logic [N_SLV-1:0]        slv_wait
);

    localparam int IDX_W  = (N_SLV > 1) ? $clog2(N_SLV) : 1;
    localparam int TCNT_W = $clog2(TIMEOUT + 1);
    localparam int OFF_W  = ADDR_W - SEL_W;
    localparam logic [TCNT_W-1:0] T_LAST = TCNT_W'(TIMEOUT - 1);

    state_t              r_state, w_state_nxt;
    logic [N_SLV-1:0]    r_sel, w_sel_nxt;
    logic [IDX_W-1:0]    r_idx, w_idx_nxt;
    logic [OFF_W-1:0]    r_addr, w_addr_nxt;
    logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
    logic                r_rd, w_rd_nxt;
    logic                r_wr, w_wr_nxt;
    logic [2:0]          r_wcnt, w_wcnt_nxt;
    logic [TCNT_W-1:0]   r_tcnt, w_tcnt_nxt;
    logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;
    logic                r_ready, w_ready_nxt;
    logic                r_err, w_err_nxt;

    logic [N_SLV-1:0]    w_onehot;
    logic                w_hit;
    logic [IDX_W-1:0]    w_idx;

    bus_decode #(
        .ADDR_W (ADDR_W),
        .N_SLV  (N_SLV),
        .SEL_W  (SEL_W),
        .IDX_W  (IDX_W),
        .BASES  (BASES)
    ) u_decode (
        .i_addr   (cpu_addr),
        .o_onehot (w_onehot),
        .o_hit    (w_hit),
        .o_idx    (w_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_idx   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_wcnt  <= '0;
            r_tcnt  <= '0;
            r_rdata <= '0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_idx   <= w_idx_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_rd    <= w_rd_nxt;
            r_wr    <= w_wr_nxt;
            r_wcnt  <= w_wcnt_nxt;
            r_tcnt  <= w_tcnt_nxt;
            r_rdata <= w_rdata_nxt;
            r_ready <= w_ready_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_idx_nxt   = r_idx;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_rd_nxt    = r_rd;
        w_wr_nxt    = r_wr;
        w_wcnt_nxt  = r_wcnt;
        w_tcnt_nxt  = r_tcnt;
        w_rdata_nxt = r_rdata;
        w_ready_nxt = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if ((cpu_read && cpu_write) || ((cpu_read || cpu_write) && !w_hit)) begin
                    w_state_nxt = DONE;
                    w_ready_nxt = 1'b1;
                    w_err_nxt   = 1'b1;
                end else if (cpu_read || cpu_write) begin
                    w_state_nxt = ACCESS;
                    w_sel_nxt   = w_onehot;
                    w_idx_nxt   = w_idx;
                    w_addr_nxt  = cpu_addr[OFF_W-1:0];
                    w_wdata_nxt = cpu_wdata;
                    w_rd_nxt    = cpu_read;
                    w_wr_nxt    = cpu_write;
                    w_wcnt_nxt  = WAITS[int'(w_idx)*3 +: 3];
                    w_tcnt_nxt  = '0;
                end
            end
            ACCESS: begin
                if (r_tcnt != '1) begin
                    w_tcnt_nxt = r_tcnt + TCNT_W'(1);
                end
                if (r_wcnt != 3'd0) begin
                    w_wcnt_nxt = r_wcnt - 3'd1;
                end
                // Completion takes precedence over a timeout landing on the same cycle.
                if (r_wcnt == 3'd0 && !slv_wait[r_idx]) begin
                    if (r_rd) begin
                        w_rdata_nxt = slv_rdata[int'(r_idx)*DATA_W +: DATA_W];
                    end
                    w_state_nxt = DONE;
                    w_ready_nxt = 1'b1;
                end else if (r_tcnt == T_LAST) begin
                    w_state_nxt = DONE;
                    w_ready_nxt = 1'b1;
                    w_err_nxt   = 1'b1;
                end
                if (w_state_nxt == DONE) begin
                    w_sel_nxt = '0;
                    w_rd_nxt  = 1'b0;
                    w_wr_nxt  = 1'b0;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign cpu_rdata = r_rdata;
    assign cpu_ready = r_ready;
    assign bus_error = r_err;
    assign slv_sel   = r_sel;
    assign slv_addr  = r_addr;
    assign slv_wdata = r_wdata;
    assign slv_read  = r_rd;
    assign slv_write = r_wr;

endmodule

// File: tb/tb_bus_fabric.sv
// tb/tb_bus_fabric.sv - self-checking bench for bus_fabric
module tb_bus_fabric;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_read;
    logic        cpu_write;
    logic [7:0]  cpu_rdata;
    logic        cpu_ready;
    logic        bus_error;
    logic [3:0]  slv_sel;
    logic [12:0] slv_addr;
    logic [7:0]  slv_wdata;
    logic        slv_read;
    logic        slv_write;
    logic [31:0] slv_rdata;
    logic [3:0]  slv_wait;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_rdata;

    int base_tab [4] = '{0, 1, 2, 3};
    int wait_tab [4] = '{0, 1, 2, 0};

    bus_fabric dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_read  (cpu_read),
        .cpu_write (cpu_write),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .bus_error (bus_error),
        .slv_sel   (slv_sel),
        .slv_addr  (slv_addr),
        .slv_wdata (slv_wdata),
        .slv_read  (slv_read),
        .slv_write (slv_write),
        .slv_rdata (slv_rdata),
        .slv_wait  (slv_wait)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after an edge with the fabric idle; the next edge is the request edge k.
    task automatic access(input logic [15:0] addr, input logic rd, input logic wr,
                          input logic [7:0] wd, input int stall, input logic [31:0] rdv,
                          input bit noise);
        int idx = -1;
        int w = 0;
        int rdy;
        int c;
        bit err;
        logic [3:0] onehot = 4'b0;
        logic [3:0] nz;
        for (int i = 3; i >= 0; i--) begin
            if (int'(addr[15:13]) == base_tab[i]) idx = i;
        end
        if ((rd && wr) || idx < 0) begin
            rdy = 1;
            err = 1'b1;
        end else begin
            w = wait_tab[idx];
            onehot = 4'(1 << idx);
            c = w + stall + 1;
            if (c <= 15) begin
                rdy = c + 1;
                err = 1'b0;
            end else begin
                rdy = 16;
                err = 1'b1;
            end
        end
        slv_rdata = rdv;
        cpu_addr  = addr;
        cpu_wdata = wd;
        cpu_read  = rd;
        cpu_write = wr;
        slv_wait  = noise ? 4'($urandom) : 4'b0;
        for (int j = 1; j <= rdy; j++) begin
            @(posedge clk);
            #1;
            if (j < rdy) begin
                chk("busy", {cpu_ready, bus_error, slv_sel, slv_read, slv_write, slv_addr, slv_wdata},
                    {2'b00, onehot, rd, wr, addr[12:0], wd});
            end else begin
                if (rd && !err) exp_rdata = rdv[idx*8 +: 8];
                chk("ready", {cpu_ready, bus_error, slv_sel, slv_read, slv_write},
                    {1'b1, err, 4'b0000, 2'b00});
                chk("rdata", cpu_rdata, exp_rdata);
                cpu_read  = 1'b0;
                cpu_write = 1'b0;
            end
            // The selected slave's wait is ignored until its fixed wait states have elapsed.
            nz = noise ? 4'($urandom) : 4'b0;
            if (idx >= 0 && j > w && j <= w + stall) slv_wait = nz | onehot;
            else if (idx >= 0 && j > w)              slv_wait = nz & ~onehot;
            else                                     slv_wait = nz;
        end
        @(posedge clk);
        #1;
        chk("idle", {cpu_ready, bus_error, slv_sel, slv_read, slv_write}, 8'h00);
        slv_wait = 4'b0;
    endtask

    initial begin
        logic [15:0] a;
        logic [1:0]  op;
        int          st;
        reset     = 1'b1;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        slv_rdata = '0;
        slv_wait  = '0;
        exp_rdata = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", {cpu_rdata, cpu_ready, bus_error, slv_sel, slv_addr, slv_wdata, slv_read, slv_write}, 64'h0);
        reset = 1'b0;

        access(16'h0123, 1'b1, 1'b0, 8'h00, 0, 32'h5A5A_5AA5, 1'b0);
        access(16'h4010, 1'b0, 1'b1, 8'h3C, 0, 32'h1122_3344, 1'b0);
        access(16'h2000, 1'b1, 1'b0, 8'h11, 3, 32'h0000_C300, 1'b0);
        access(16'h6000, 1'b1, 1'b0, 8'h22, 40, 32'hDD00_0000, 1'b0);
        access(16'h1234, 1'b1, 1'b1, 8'h33, 0, 32'hFFFF_FFFF, 1'b0);
        access(16'hE000, 1'b1, 1'b0, 8'h44, 0, 32'hFFFF_FFFF, 1'b0);
        access(16'h0040, 1'b1, 1'b0, 8'h55, 14, 32'h0000_0077, 1'b0);
        access(16'h0040, 1'b1, 1'b0, 8'h55, 15, 32'h0000_0088, 1'b0);

        cpu_addr  = 16'h4020;
        cpu_wdata = 8'h77;
        cpu_write = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset     = 1'b1;
        cpu_write = 1'b0;
        @(posedge clk);
        #1;
        exp_rdata = 8'h00;
        chk("midreset", {cpu_rdata, cpu_ready, bus_error, slv_sel, slv_addr, slv_wdata, slv_read, slv_write}, 64'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("noready", {cpu_ready, bus_error, slv_sel}, 6'h00);
        access(16'h2ABC, 1'b1, 1'b0, 8'h00, 0, 32'h0000_9600, 1'b0);

        for (int n = 0; n < 40; n++) begin
            a  = 16'($urandom);
            a[15] = ($urandom_range(0, 3) == 0);
            op = 2'($urandom_range(0, 6) == 0 ? 2 : $urandom_range(0, 1));
            st = ($urandom_range(0, 7) == 0) ? $urandom_range(12, 16) : $urandom_range(0, 4);
            access(a, op != 2'd1, op != 2'd0, 8'($urandom), st, $urandom, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_fabric.md
Name: bus_fabric

Overview:
- Parametrised memory-mapped interconnect between the cpu and N slaves (gpu, ram, future peripherals).
- Replaces hard-wired single-region chip-select logic with:
  - a per-slave decode table;
  - per-slave programmable wait states;
  - slave-driven stall;
  - a timeout-protected ready/error handshake back to the cpu.
- Sits at board level; all slave select, read and write strobes come from here.

Parameters:
- ADDR_W, 16, cpu address width
- DATA_W, 8, data width
- N_SLV, 4, number of slaves
- SEL_W, 3, address MSBs used for decode
- BASES, {3'd3,3'd2,3'd1,3'd0}, packed N_SLV*SEL_W; slave i selected when addr[ADDR_W-1 -: SEL_W]==BASES[i]
- WAITS, {3'd0,3'd2,3'd1,3'd0}, packed N_SLV*3; fixed wait states per slave
- TIMEOUT, 15, max ACCESS cycles before abort; must exceed max(WAITS)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- cpu_addr  in  ADDR_W  request address
- cpu_wdata  in  DATA_W  write data
- cpu_read  in  1  read request, held until cpu_ready
- cpu_write  in  1  write request, held until cpu_ready
- cpu_rdata  out  DATA_W  registered read data
- cpu_ready  out  1  one-cycle completion pulse
- bus_error  out  1  qualifies cpu_ready: access failed
- slv_sel  out  N_SLV  one-hot select
- slv_addr  out  ADDR_W-SEL_W  latched offset
- slv_wdata  out  DATA_W  latched write data
- slv_read  out  1  read strobe (AND with slv_sel[i] at slave)
- slv_write  out  1  write strobe
- slv_rdata  in  N_SLV*DATA_W  per-slave read data
- slv_wait  in  N_SLV  per-slave stall request

Behaviour:
- Clock: one clock, clk. Reset: synchronous, active-high (reset).
- Reset values:
  - state=IDLE;
  - slv_sel=0, slv_read=0, slv_write=0, slv_addr=0, slv_wdata=0;
  - cpu_rdata=0, cpu_ready=0, bus_error=0;
  - counters=0.
- Reset mid-access: everything above is cleared at that edge, no ready pulse.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay.
  - cpu_read and cpu_write both high: go to DONE with bus_error=1, no slave touched.
  - Exactly one high, no BASES match: go to DONE with bus_error=1.
  - Exactly one high, match:
    - latch slave index (lowest index wins on overlap), offset, wdata, op;
    - load wait counter with WAITS[i] and timeout counter with 0;
    - go to ACCESS.
- ACCESS:
  - slv_sel[i], slv_addr, slv_wdata and the op strobe are held constant for every ACCESS cycle.
  - Each cycle the timeout counter increments.
  - Wait counter >0: decrement.
  - Wait counter ==0 and slv_wait[i]==0:
    - capture slv_rdata[i] into cpu_rdata if read; writes leave cpu_rdata unchanged;
    - go to DONE with bus_error=0.
  - Timeout counter reaches TIMEOUT-1 without completing: go to DONE with bus_error=1; cpu_rdata unchanged.
  - slv_wait is sampled only once the wait counter is 0.
- DONE:
  - cpu_ready=1 for exactly this cycle; bus_error valid with it.
  - Strobes and slv_sel are 0.
  - Next state IDLE unconditionally.
  - The cpu drops its request in the cycle it sees ready; a still-held request is re-sampled in IDLE as a new access.
- Latency (request first seen at IDLE edge k; W=WAITS[i], S=stall cycles):
  - cpu_ready is high in cycle k+2+W+S.
  - Minimum 2 cycles.
  - Decode error: ready at k+1.
- Outputs are registered; no combinational path from cpu_* to slv_*.
- Counters: wait counter 3 bits; timeout counter $clog2(TIMEOUT+1) bits; neither wraps.

Decomposition:
- Shared package bus_pkg holds:
  - state enum (IDLE, ACCESS, DONE);
  - the board region constants (RAM=3'd0, GPU=3'd1, IO=3'd2, ROM=3'd3);
  - the default BASES/WAITS packing helpers.
- One natural sub-module: bus_decode. It is combinational and maps the address to a one-hot match vector plus an index, using a lowest-index priority encoder. The FSM stays in bus_fabric.

Test Plan:
- Read slave 0 (W=0): addr 16'h0123, slv_rdata[0]=8'hA5 -> slv_sel=4'b0001, slv_addr=13'h0123 for 1 cycle; cpu_ready 2 cycles after request; cpu_rdata=8'hA5; bus_error=0.
- Write slave 2 (W=2): addr 16'h4010, wdata 8'h3C -> slv_write with slv_wdata=8'h3C held 3 cycles; ready at k+4; cpu_rdata unchanged.
- Slave stall: slave 1 (W=1), slv_wait[1] high 3 cycles after the counter hits 0 -> ready at k+6; strobes stable throughout.
- Timeout: slv_wait[3] stuck high, TIMEOUT=15 -> ready with bus_error=1 at k+16; slv_sel drops same cycle.
- Decode errors: read and write both high -> ready and bus_error at k+1, slv_sel never asserted; repeat with BASES lacking 3'd7 and addr 16'hE000 -> same response.
- Reset mid-access: reset asserted in the 2nd ACCESS cycle of a W=2 access -> next cycle all outputs 0, state IDLE, no ready pulse; a following read completes normally.
